// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multi-cycle ALU (alu_mc) and its iterative
// multiplier (alu_mul_iter).
//   - opcode constants for the nine legal operations
//   - FSM state constants for the ALU controller
//   - packed status-flag struct carried alongside each result
// -----------------------------------------------------------------------------
package alu_pkg;

   // Opcodes. Any value not listed here is reported as an illegal operation.
   localparam logic [7:0] OP_ADD = 8'h01;
   localparam logic [7:0] OP_SUB = 8'h02;
   localparam logic [7:0] OP_MUL = 8'h03;
   localparam logic [7:0] OP_AND = 8'h04;
   localparam logic [7:0] OP_OR  = 8'h05;
   localparam logic [7:0] OP_XOR = 8'h06;
   localparam logic [7:0] OP_SLL = 8'h07;
   localparam logic [7:0] OP_SRL = 8'h08;
   localparam logic [7:0] OP_SRA = 8'h09;

   // Controller states. Plain constants keep the encoding visible to older
   // tools and to anyone probing the state register in a waveform.
   typedef logic [1:0] alu_state_t;
   localparam alu_state_t ST_IDLE = 2'd0;
   localparam alu_state_t ST_MUL  = 2'd1;
   localparam alu_state_t ST_DONE = 2'd2;

   // Status flags that travel with every result.
   typedef struct packed {
      logic z;
      logic c;
      logic err;
   } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// -----------------------------------------------------------------------------
// alu_mul_iter
// Iterative unsigned multiplier producing the low WIDTH bits of a*b. The
// operands are split into LIMB-wide limbs and one partial product
// a_limb[i]*b_limb[j] << (LIMB*(i+j)) is accumulated per cycle, visiting the
// K = (WIDTH/LIMB)^2 limb pairs i-major, j-minor.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (also used for flush)
//   start    in   one-cycle pulse: latch a/b, clear accumulator and counter
//   a, b     in   WIDTH-bit operands, sampled on start
//   done     out  high during the cycle in which the K-th accumulate happens
//   product  out  accumulator plus the current partial product; this is the
//                 final result whenever done is high
// -----------------------------------------------------------------------------
module alu_mul_iter #(
   parameter int WIDTH = 32,
   parameter int LIMB  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int N     = WIDTH / LIMB;
   localparam int K     = N * N;
   localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

   logic [WIDTH-1:0]          a_q;
   logic [WIDTH-1:0]          b_q;
   logic [WIDTH-1:0]          acc;
   logic [CNT_W-1:0]          cnt;
   logic                      busy;
   int                        idx;
   int                        idx_i;
   int                        idx_j;
   logic [LIMB-1:0]           a_limb;
   logic [LIMB-1:0]           b_limb;
   logic [2*LIMB-1:0]         pp;
   logic [WIDTH+2*LIMB-1:0]   pp_wide;
   logic [WIDTH-1:0]          partial;

   // Select the limb pair addressed by the counter and form its partial
   // product. The product is widened before shifting so that nothing is lost
   // before the final truncation to WIDTH bits.
   always_comb begin
      idx     = int'(cnt);
      idx_i   = idx / N;
      idx_j   = idx % N;
      a_limb  = a_q[idx_i*LIMB +: LIMB];
      b_limb  = b_q[idx_j*LIMB +: LIMB];
      pp      = {{LIMB{1'b0}}, a_limb} * {{LIMB{1'b0}}, b_limb};
      pp_wide = {{WIDTH{1'b0}}, pp} << (LIMB * (idx_i + idx_j));
      partial = pp_wide[WIDTH-1:0];
   end

   assign product = acc + partial;
   assign done    = busy && (cnt == LAST);

   // Operand capture and accumulation. A start restarts the sequence even if
   // one were somehow still running; the controller never does that.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q  <= '0;
         b_q  <= '0;
         acc  <= '0;
         cnt  <= '0;
         busy <= 1'b0;
      end else if (start) begin
         a_q  <= a;
         b_q  <= b;
         acc  <= '0;
         cnt  <= '0;
         busy <= 1'b1;
      end else if (busy) begin
         acc <= product;
         cnt <= cnt + 1'b1;
         if (cnt == LAST) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc
// Parametrised multi-cycle integer ALU with valid/ready handshakes on both
// sides. Single-cycle ops (ADD/SUB/logic/shifts) return one cycle after
// acceptance; MUL runs on alu_mul_iter and returns K+1 cycles after
// acceptance. One operation is in flight at a time; a result is held stable
// until the consumer takes it.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr           synchronous flush, same effect as rst
//   in_valid      request valid
//   in_ready      request accepted when in_valid && in_ready
//   op            8-bit opcode
//   key_in        tag returned with the result of this request
//   in_a, in_b    operands
//   out_valid     result valid
//   out_ready     consumer ready
//   out           result
//   key_out       tag of the request that produced out
//   flag_z        out == 0
//   flag_c        carry (ADD) / no-borrow (SUB), otherwise 0
//   flag_err      illegal opcode
// -----------------------------------------------------------------------------
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int LIMB   = 16,
   parameter int KEY_W  = 8,
   parameter int MUL_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       op,
   input  logic [KEY_W-1:0] key_in,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [KEY_W-1:0] key_out,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_err
);

   if (WIDTH % LIMB != 0) begin : g_width_check
      $fatal(1, "alu_mc: WIDTH (%0d) must be a multiple of LIMB (%0d)", WIDTH, LIMB);
   end

   localparam int SHW = $clog2(WIDTH);

   alu_state_t       state;
   alu_flags_t       flags_q;
   logic [KEY_W-1:0] mul_key;
   logic             flush;
   logic             accept;
   logic             mul_start;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;

   logic [WIDTH:0]   sum_add;
   logic [WIDTH:0]   sum_sub;
   logic [SHW-1:0]   sh;
   logic [WIDTH-1:0] res;
   logic             res_c;
   logic             res_err;
   logic             is_mul;

   assign flush     = rst || clr;
   assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
   assign out_valid = (state == ST_DONE);
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && is_mul;

   assign flag_z   = flags_q.z;
   assign flag_c   = flags_q.c;
   assign flag_err = flags_q.err;

   // Single-cycle datapath and opcode decode. SUB is formed as a + ~b + 1 so
   // its carry out is the no-borrow indication. MUL only raises is_mul here;
   // when the multiplier is not built it falls through to the illegal path.
   always_comb begin
      sum_add = {1'b0, in_a} + {1'b0, in_b};
      sum_sub = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};
      sh      = in_b[SHW-1:0];
      res     = '0;
      res_c   = 1'b0;
      res_err = 1'b0;
      is_mul  = 1'b0;
      case (op)
         OP_ADD: begin
            res   = sum_add[WIDTH-1:0];
            res_c = sum_add[WIDTH];
         end
         OP_SUB: begin
            res   = sum_sub[WIDTH-1:0];
            res_c = sum_sub[WIDTH];
         end
         OP_MUL: begin
            if (MUL_EN != 0) begin
               is_mul = 1'b1;
            end else begin
               res_err = 1'b1;
            end
         end
         OP_AND:  res = in_a & in_b;
         OP_OR:   res = in_a | in_b;
         OP_XOR:  res = in_a ^ in_b;
         OP_SLL:  res = in_a << sh;
         OP_SRL:  res = in_a >> sh;
         OP_SRA:  res = WIDTH'($signed(in_a) >>> sh);
         default: res_err = 1'b1;
      endcase
   end

   if (MUL_EN != 0) begin : g_mul
      alu_mul_iter #(
         .WIDTH (WIDTH),
         .LIMB  (LIMB)
      ) u_mul (
         .clk     (clk),
         .rst     (flush),
         .start   (mul_start),
         .a       (in_a),
         .b       (in_b),
         .done    (mul_done),
         .product (mul_product)
      );
   end else begin : g_no_mul
      assign mul_done    = 1'b0;
      assign mul_product = '0;
   end

   // Controller. IDLE and DONE share the accept path so a new request can be
   // taken in the same cycle the previous result is handed over. The MUL key
   // is parked in mul_key so key_out keeps describing the result on out
   // until the product is ready.
   always_ff @(posedge clk) begin
      if (flush) begin
         state   <= ST_IDLE;
         out     <= '0;
         key_out <= '0;
         flags_q <= '0;
         mul_key <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  if (is_mul) begin
                     mul_key <= key_in;
                     state   <= ST_MUL;
                  end else begin
                     out         <= res;
                     key_out     <= key_in;
                     flags_q.z   <= (res == '0);
                     flags_q.c   <= res_c;
                     flags_q.err <= res_err;
                     state       <= ST_DONE;
                  end
               end else if ((state == ST_DONE) && out_ready) begin
                  state <= ST_IDLE;
               end
            end
            ST_MUL: begin
               if (mul_done) begin
                  out         <= mul_product;
                  key_out     <= mul_key;
                  flags_q.z   <= (mul_product == '0);
                  flags_q.c   <= 1'b0;
                  flags_q.err <= 1'b0;
                  state       <= ST_DONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
